// File: rtl/rv32i_regfile_dbg_ctrl_pkg.sv
// Shared definitions for the RV32I debug register-file access controller:
// data widths, the debug address map, the controller states and the bundle
// of pipeline-to-register-file control signals.
package rv32i_regfile_dbg_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int DBG_ADDR_W = 6;

  // Debug address map: 0-31 are GPRs, 0x20 is the PC, 0x21-0x3F reserved.
  localparam logic [DBG_ADDR_W-1:0] DBG_ADDR_PC = 6'h20;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_HALTED  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_GPR  = 2'd0,
    OP_PC   = 2'd1,
    OP_RSVD = 2'd2
  } op_kind_e;

  // Everything the pipeline drives into the register file; the controller
  // either forwards it untouched or substitutes its own debug access.
  typedef struct packed {
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] new_rd;
    logic [XLEN-1:0] new_pc;
    logic            update_pc;
    logic            stall;
  } pipe_ctl_t;

  // Classify a debug address into GPR, PC or reserved space.
  function automatic op_kind_e decode_addr(input logic [DBG_ADDR_W-1:0] addr);
    if (!addr[DBG_ADDR_W-1]) return OP_GPR;
    if (addr == DBG_ADDR_PC) return OP_PC;
    return OP_RSVD;
  endfunction

endpackage

// File: rtl/rv32i_regfile_dbg_ctrl_if.sv
// Debug requester port: halt/resume control plus the req/ack register access
// handshake. The debugger is the master, the controller the slave.
interface rv32i_regfile_dbg_ctrl_if;
  import rv32i_regfile_dbg_ctrl_pkg::*;

  logic                  dbg_halt_req;
  logic                  dbg_resume_req;
  logic                  dbg_halted;
  logic                  dbg_req;
  logic                  dbg_we;
  logic [DBG_ADDR_W-1:0] dbg_addr;
  logic [XLEN-1:0]       dbg_wdata;
  logic                  dbg_ack;
  logic [XLEN-1:0]       dbg_rdata;

  modport master (
    output dbg_halt_req, dbg_resume_req, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_halted, dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_halt_req, dbg_resume_req, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_halted, dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/rv32i_regfile_dbg_ctrl.sv
// Debug access controller between the RV32I pipeline and the register file.
// In RUN the pipeline talks to the register file directly. A halt request
// stalls the pipeline for DRAIN_CYCLES so in-flight rd writes retire, then
// the debugger may read/write x1..x31 and the PC through a req/ack handshake
// until it asks to resume.
module rv32i_regfile_dbg_ctrl
  import rv32i_regfile_dbg_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  rv32i_regfile_dbg_ctrl_if.slave        dbg_if,
  input  pipe_ctl_t                      cpu_i,
  output pipe_ctl_t                      rf_o,
  input  logic [XLEN-1:0]                rf_rs1_i,
  input  logic [XLEN-1:0]                rf_pc_i
);

  localparam int              CNT_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  drain_cnt_q;
  logic              halted_q;
  logic              ack_q;
  logic [XLEN-1:0]   rdata_q;

  op_kind_e op_kind;
  logic     write_accept;

  assign op_kind      = decode_addr(dbg_if.dbg_addr);
  assign write_accept = (state_q == ST_HALTED) && dbg_if.dbg_req && dbg_if.dbg_we;

  assign dbg_if.dbg_halted = halted_q;
  assign dbg_if.dbg_ack    = ack_q;
  assign dbg_if.dbg_rdata  = rdata_q;

  // Control FSM: run/drain/halt sequencing and debug op execution, with the
  // handshake outputs registered alongside the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values of the others.
    if (!reset_n) begin
      state_q     <= RESET_HALTED ? ST_HALTED : ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= RESET_HALTED;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          // Halt is the only exit; a simultaneous resume is meaningless here.
          if (dbg_if.dbg_halt_req) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_W'(1);
          end
        end
        ST_HALTED: begin
          // A pending op takes priority over resume.
          if (dbg_if.dbg_req) begin
            if (!dbg_if.dbg_we && op_kind == OP_GPR) begin
              state_q <= ST_RD_WAIT;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              if (!dbg_if.dbg_we) rdata_q <= (op_kind == OP_PC) ? rf_pc_i : '0;
            end
          end else if (dbg_if.dbg_resume_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          // rs1 was addressed in the accept cycle; its data arrives now.
          rdata_q <= rf_rs1_i;
          state_q <= ST_ACK;
          ack_q   <= 1'b1;
        end
        ST_ACK: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Register-file port mux: pipeline pass-through in RUN, forced stall in
  // DRAIN, debug-owned access while halted.
  always_comb begin
    // NOTE: rf_o receives a complete default before any override, so no path
    // through this block leaves a field unassigned and no latch is inferred.
    rf_o = cpu_i;
    if (state_q == ST_DRAIN) begin
      rf_o.stall = 1'b1;
    end else if (state_q != ST_RUN) begin
      rf_o.rs1_idx   = dbg_if.dbg_addr[4:0];
      rf_o.rs2_idx   = '0;
      rf_o.rd_idx    = '0;
      rf_o.new_rd    = dbg_if.dbg_wdata;
      rf_o.new_pc    = rf_pc_i - XLEN'(4);
      rf_o.update_pc = 1'b0;
      rf_o.stall     = 1'b1;
      // Writes take one unstalled cycle. The register file loads new_pc+4,
      // so new_pc is biased by -4: GPR writes keep the PC, PC writes land
      // exactly on dbg_wdata. Writes to x0 use rd index 0 and are dropped.
      if (write_accept) begin
        case (op_kind)
          OP_GPR: begin
            rf_o.stall     = 1'b0;
            rf_o.update_pc = 1'b1;
            rf_o.rd_idx    = dbg_if.dbg_addr[4:0];
          end
          OP_PC: begin
            rf_o.stall     = 1'b0;
            rf_o.update_pc = 1'b1;
            rf_o.new_pc    = dbg_if.dbg_wdata - XLEN'(4);
          end
          default: rf_o.stall = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32i_regfile_dbg_ctrl.sv
// Bench for rv32i_regfile_dbg_ctrl: a behavioural register file sits on the
// rf_* side, a transaction-level reference (GPR array + PC) predicts debug
// read data, and a table of debug ops plus randomized ops and hand-written
// halt/resume/reset sequences exercise the controller.
module tb_rv32i_regfile_dbg_ctrl;
  import rv32i_regfile_dbg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_regfile_dbg_ctrl_if bus ();
  rv32i_regfile_dbg_ctrl_if bus_h ();

  pipe_ctl_t   cpu;
  pipe_ctl_t   rf;
  pipe_ctl_t   rf_h;
  logic [31:0] m_rs1;
  logic [31:0] m_pc;
  logic [31:0] mem [32] = '{default: 32'h0};
  logic [31:0] h_rs1 = 32'h0;
  logic [31:0] h_pc  = 32'hCAFE_0000;

  rv32i_regfile_dbg_ctrl #(.DRAIN_CYCLES(3), .RESET_HALTED(1'b0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dbg_if   (bus),
    .cpu_i    (cpu),
    .rf_o     (rf),
    .rf_rs1_i (m_rs1),
    .rf_pc_i  (m_pc)
  );

  rv32i_regfile_dbg_ctrl #(.DRAIN_CYCLES(3), .RESET_HALTED(1'b1)) dut_h (
    .clk      (clk),
    .reset_n  (reset_n),
    .dbg_if   (bus_h),
    .cpu_i    (cpu),
    .rf_o     (rf_h),
    .rf_rs1_i (h_rs1),
    .rf_pc_i  (h_pc)
  );

  // Behavioural register file: registered rs1 read, rd writes land even when
  // stalled, PC advances (or loads new_pc+4) only when not stalled.
  always @(posedge clk) begin
    m_rs1 <= (rf.rs1_idx == 5'd0) ? 32'h0 : mem[rf.rs1_idx];
    if (rf.rd_idx != 5'd0) mem[rf.rd_idx] <= rf.new_rd;
    if (!reset_n)      m_pc <= 32'h0000_1000;
    else if (!rf.stall) m_pc <= rf.update_pc ? rf.new_pc + 32'd4 : m_pc + 32'd4;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_gpr [32];
  logic [31:0] ref_pc;

  typedef struct {
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    string       name;
  } vec_t;
  vec_t vq [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [5:0] a);
    if (a < 6'd32) return (a == 6'd0) ? 32'h0 : ref_gpr[a[4:0]];
    if (a == 6'h20) return ref_pc;
    return 32'h0;
  endfunction

  function automatic int ref_lat(input bit we, input logic [5:0] a);
    return (!we && a < 6'd32) ? 2 : 1;
  endfunction

  task automatic ref_write(input logic [5:0] a, input logic [31:0] d);
    if (a < 6'd32) begin
      if (a != 6'd0) ref_gpr[a[4:0]] = d;
    end else if (a == 6'h20) begin
      ref_pc = d;
    end
  endtask

  // Random pipeline traffic; the rd write it carries lands at the next edge.
  task automatic cpu_random();
    cpu.rs1_idx   = 5'($urandom);
    cpu.rs2_idx   = 5'($urandom);
    cpu.rd_idx    = 5'($urandom);
    cpu.new_rd    = $urandom;
    cpu.new_pc    = $urandom;
    cpu.update_pc = 1'($urandom);
    cpu.stall     = 1'($urandom);
    if (cpu.rd_idx != 5'd0) ref_gpr[cpu.rd_idx] = cpu.new_rd;
  endtask

  task automatic add_vec(input bit we, input logic [5:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.name = name;
    vq.push_back(v);
  endtask

  // One debug op from a HALTED-idle cycle: measure accept-to-ack latency,
  // check read data, then drop req the cycle after ack.
  task automatic run_op(input bit we, input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_lat, input string name);
    int lat;
    lat = -1;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.dbg_ack) begin
        lat = i;
        break;
      end
    end
    check({name, "_lat"}, lat, exp_lat);
    if (!we) check({name, "_rdata"}, bus.dbg_rdata, exp_rd);
    step();
    bus.dbg_req = 1'b0;
    check({name, "_ack_pulse"}, bus.dbg_ack, 1'b0);
    if (we) ref_write(addr, wdata);
  endtask

  initial begin
    int n;
    int acks;
    logic [5:0] a;
    bit w;

    cpu = '0;
    {bus.dbg_halt_req, bus.dbg_resume_req, bus.dbg_req, bus.dbg_we} = '0;
    bus.dbg_addr = '0; bus.dbg_wdata = '0;
    {bus_h.dbg_halt_req, bus_h.dbg_resume_req, bus_h.dbg_req, bus_h.dbg_we} = '0;
    bus_h.dbg_addr = '0; bus_h.dbg_wdata = '0;
    foreach (ref_gpr[i]) ref_gpr[i] = 32'h0;
    ref_pc = 32'h0;

    add_vec(1'b1, 6'd5,  32'hDEAD_BEEF, 32'h0,         1, "wr_x5");
    add_vec(1'b0, 6'd5,  32'h0,         32'hDEAD_BEEF, 2, "rd_x5");
    add_vec(1'b1, 6'd0,  32'h1234_5678, 32'h0,         1, "wr_x0");
    add_vec(1'b0, 6'd0,  32'h0,         32'h0,         2, "rd_x0");
    add_vec(1'b0, 6'd7,  32'h0,         32'hA5A5_0007, 2, "rd_x7_halt_cycle");
    add_vec(1'b0, 6'd9,  32'h0,         32'h5A5A_0009, 2, "rd_x9_drain");
    add_vec(1'b1, 6'h20, 32'h0000_0100, 32'h0,         1, "wr_pc");
    add_vec(1'b0, 6'h20, 32'h0,         32'h0000_0100, 1, "rd_pc");
    add_vec(1'b1, 6'd31, 32'hFFFF_FFFF, 32'h0,         1, "wr_x31");
    add_vec(1'b0, 6'h20, 32'h0,         32'h0000_0100, 1, "rd_pc_after_gpr_wr");
    add_vec(1'b0, 6'd31, 32'h0,         32'hFFFF_FFFF, 2, "rd_x31");
    add_vec(1'b1, 6'h21, 32'h1111_1111, 32'h0,         1, "wr_rsvd");
    add_vec(1'b0, 6'h3F, 32'h0,         32'h0,         1, "rd_rsvd");

    // Reset state of both instances.
    repeat (3) step();
    check("rst_halted", bus.dbg_halted, 1'b0);
    check("rst_ack", bus.dbg_ack, 1'b0);
    check("rst_rdata", bus.dbg_rdata, 32'h0);
    check("rsth_halted", bus_h.dbg_halted, 1'b1);
    check("rsth_stall", rf_h.stall, 1'b1);
    check("rsth_rd_idx", rf_h.rd_idx, 5'd0);
    cpu_random();
    #1;
    check("rst_passthru", rf, cpu);
    reset_n = 1'b1;

    // Debug-boot instance: PC read right out of reset, then resume.
    bus_h.dbg_req = 1'b1; bus_h.dbg_we = 1'b0; bus_h.dbg_addr = 6'h20;
    step();
    check("h_pc_ack", bus_h.dbg_ack, 1'b1);
    check("h_pc_rdata", bus_h.dbg_rdata, 32'hCAFE_0000);
    step();
    bus_h.dbg_req = 1'b0;
    bus_h.dbg_resume_req = 1'b1;
    step();
    bus_h.dbg_resume_req = 1'b0;
    check("h_resume", bus_h.dbg_halted, 1'b0);

    // RUN: random pipeline traffic passes straight through.
    for (int i = 0; i < 30; i++) begin
      cpu_random();
      #1;
      check("run_pass", rf, cpu);
      step();
    end

    // Halt with an rd write in the halt cycle and another during drain.
    cpu = '0;
    cpu.rd_idx = 5'd7; cpu.new_rd = 32'hA5A5_0007;
    ref_gpr[7] = 32'hA5A5_0007;
    bus.dbg_halt_req = 1'b1;
    step();
    bus.dbg_halt_req = 1'b0;
    cpu.rd_idx = 5'd9; cpu.new_rd = 32'h5A5A_0009;
    ref_gpr[9] = 32'h5A5A_0009;
    #1;
    check("drain_stall", rf.stall, 1'b1);
    check("drain_rd_pass", rf.rd_idx, 5'd9);
    check("drain_not_halted", bus.dbg_halted, 1'b0);
    ref_pc = m_pc;
    n = 1;
    while (!bus.dbg_halted && n < 20) begin
      step();
      n++;
      cpu = '0;
    end
    check("halt_latency", n, 4);
    check("pc_frozen", m_pc, ref_pc);

    // Table-driven debug ops.
    foreach (vq[i]) run_op(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].rdata, vq[i].lat, vq[i].name);

    // Randomized debug ops against the reference.
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      case ($urandom % 4)
        0, 1:    a = 6'($urandom % 32);
        2:       a = 6'h20;
        default: a = 6'(33 + $urandom % 31);
      endcase
      run_op(w, a, $urandom, ref_read(a), ref_lat(w, a), "rand");
    end

    // PC write then resume: first fetch at the written PC.
    run_op(1'b1, 6'h20, 32'h0000_0100, 32'h0, 1, "wr_pc_resume");
    bus.dbg_resume_req = 1'b1;
    step();
    bus.dbg_resume_req = 1'b0;
    check("resume_halted", bus.dbg_halted, 1'b0);
    check("resume_pc", m_pc, 32'h0000_0100);
    cpu_random();
    #1;
    check("resume_pass", rf, cpu);
    step();
    cpu = '0;

    // Request while running is not acked; halt+resume together still halts.
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 6'd5;
    acks = 0;
    repeat (5) begin
      step();
      if (bus.dbg_ack) acks++;
    end
    check("no_ack_in_run", acks, 0);
    bus.dbg_halt_req = 1'b1;
    bus.dbg_resume_req = 1'b1;
    step();
    bus.dbg_halt_req = 1'b0;
    bus.dbg_resume_req = 1'b0;
    check("halt_wins", rf.stall, 1'b1);
    n = 1;
    while (!bus.dbg_ack && n < 20) begin
      step();
      n++;
    end
    check("req_after_halt_lat", n, 6);
    check("req_after_halt_rdata", bus.dbg_rdata, ref_read(6'd5));
    step();
    bus.dbg_req = 1'b0;
    ref_pc = m_pc;

    // Reset while a GPR read waits for data: op aborted, back to RUN.
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 6'd31;
    step();
    reset_n = 1'b0;
    bus.dbg_req = 1'b0;
    step();
    check("rst_mid_ack", bus.dbg_ack, 1'b0);
    check("rst_mid_rdata", bus.dbg_rdata, 32'h0);
    check("rst_mid_halted", bus.dbg_halted, 1'b0);
    check("rst_mid_h_halted", bus_h.dbg_halted, 1'b1);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_random();
      #1;
      check("post_rst_pass", rf, cpu);
      step();
      if (bus.dbg_ack) acks++;
    end
    check("post_rst_no_ack", acks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
